// File: rtl/csr_exc_ctrl_if.sv
// WB-stage CSR port plus exception/ertn commit, interrupt lines and redirect targets.
interface csr_exc_ctrl_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, ex_entry, ertn_entry
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, ex_entry, ertn_entry
  );
endinterface

// File: rtl/csr_exc_ctrl.sv
// CSR file, exception/ertn commit sequencing, constant timer and interrupt request.
// Reads and redirect targets are combinational from current state.
module csr_exc_ctrl (
  input  logic          clk,
  input  logic          resetn,
  csr_exc_ctrl_if.slave io_bus
);

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_PRMD   = 14'h0001;
  localparam logic [13:0] CSR_ECFG   = 14'h0004;
  localparam logic [13:0] CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_BADV   = 14'h0007;
  localparam logic [13:0] CSR_EENTRY = 14'h000c;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;
  localparam logic [13:0] CSR_SAVE1  = 14'h0031;
  localparam logic [13:0] CSR_SAVE2  = 14'h0032;
  localparam logic [13:0] CSR_SAVE3  = 14'h0033;
  localparam logic [13:0] CSR_TID    = 14'h0040;
  localparam logic [13:0] CSR_TCFG   = 14'h0041;
  localparam logic [13:0] CSR_TVAL   = 14'h0042;
  localparam logic [13:0] CSR_TICLR  = 14'h0044;

  localparam logic [5:0]  ECODE_ADEF = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;

  logic [1:0]  r_crmd_plv;
  logic        r_crmd_ie;
  logic        r_crmd_da;
  logic        r_crmd_pg;
  logic [1:0]  r_prmd_pplv;
  logic        r_prmd_pie;
  logic [12:0] r_ecfg_lie;
  logic [12:0] r_estat_is;
  logic [5:0]  r_estat_ecode;
  logic [8:0]  r_estat_esubcode;
  logic [31:0] r_era;
  logic [31:0] r_badv;
  logic [25:0] r_eentry_va;
  logic [31:0] r_save [4];
  logic [31:0] r_tid;
  logic        r_tcfg_en;
  logic        r_tcfg_per;
  logic [29:0] r_tcfg_initval;
  logic [31:0] r_tval;

  logic [31:0] w_rvalue;
  logic [31:0] w_wdata;
  logic        w_wr_en;
  logic        w_wr_tcfg;
  logic        w_ticlr;
  logic        w_timer_fire;
  logic [31:0] w_tval_next;
  logic        w_unused;

  // Read mux; unlisted bits and unknown indices read as zero.
  always_comb begin
    w_rvalue = 32'd0;
    case (io_bus.csr_num)
      CSR_CRMD:   w_rvalue = {27'd0, r_crmd_pg, r_crmd_da, r_crmd_ie, r_crmd_plv};
      CSR_PRMD:   w_rvalue = {29'd0, r_prmd_pie, r_prmd_pplv};
      CSR_ECFG:   w_rvalue = {19'd0, r_ecfg_lie};
      CSR_ESTAT:  w_rvalue = {1'b0, r_estat_esubcode, r_estat_ecode, 3'd0, r_estat_is};
      CSR_ERA:    w_rvalue = r_era;
      CSR_BADV:   w_rvalue = r_badv;
      CSR_EENTRY: w_rvalue = {r_eentry_va, 6'd0};
      CSR_SAVE0:  w_rvalue = r_save[0];
      CSR_SAVE1:  w_rvalue = r_save[1];
      CSR_SAVE2:  w_rvalue = r_save[2];
      CSR_SAVE3:  w_rvalue = r_save[3];
      CSR_TID:    w_rvalue = r_tid;
      CSR_TCFG:   w_rvalue = {r_tcfg_initval, r_tcfg_per, r_tcfg_en};
      CSR_TVAL:   w_rvalue = r_tval;
      default:    w_rvalue = 32'd0;
    endcase
  end

  // Commit events pre-empt a software write in the same cycle.
  assign w_wr_en   = io_bus.csr_we & ~io_bus.wb_ex & ~io_bus.ertn_flush;
  assign w_wdata   = (io_bus.csr_wmask & io_bus.csr_wvalue) | (~io_bus.csr_wmask & w_rvalue);
  assign w_wr_tcfg = w_wr_en && (io_bus.csr_num == CSR_TCFG);
  assign w_ticlr   = w_wr_en && (io_bus.csr_num == CSR_TICLR) && w_wdata[0];

  // A TCFG write reloads the counter, so it is not a 1->0 transition that edge.
  assign w_timer_fire = r_tcfg_en && (r_tval == 32'd1) && !w_wr_tcfg;

  always_comb begin
    w_tval_next = r_tval;
    if (w_wr_tcfg) begin
      w_tval_next = {w_wdata[31:2], 2'b00};
    end else if (r_tcfg_en) begin
      if (r_tval != 32'd0) begin
        w_tval_next = r_tval - 32'd1;
      end else if (r_tcfg_per) begin
        w_tval_next = {r_tcfg_initval, 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_crmd_plv       <= 2'd0;
      r_crmd_ie        <= 1'b0;
      r_crmd_da        <= 1'b1;
      r_crmd_pg        <= 1'b0;
      r_prmd_pplv      <= 2'd0;
      r_prmd_pie       <= 1'b0;
      r_ecfg_lie       <= 13'd0;
      r_estat_is       <= 13'd0;
      r_estat_ecode    <= 6'd0;
      r_estat_esubcode <= 9'd0;
      r_era            <= 32'd0;
      r_badv           <= 32'd0;
      r_eentry_va      <= 26'd0;
      r_save           <= '{default: 32'd0};
      r_tid            <= 32'd0;
      r_tcfg_en        <= 1'b0;
      r_tcfg_per       <= 1'b0;
      r_tcfg_initval   <= 30'd0;
      r_tval           <= 32'd0;
    end else begin
      r_tval            <= w_tval_next;
      r_estat_is[9:2]   <= io_bus.hw_int_in;
      r_estat_is[10]    <= 1'b0;
      r_estat_is[12]    <= io_bus.ipi_int_in;
      if (w_timer_fire) begin
        r_estat_is[11] <= 1'b1;
      end else if (w_ticlr) begin
        r_estat_is[11] <= 1'b0;
      end

      if (io_bus.wb_ex) begin
        r_prmd_pplv      <= r_crmd_plv;
        r_prmd_pie       <= r_crmd_ie;
        r_crmd_plv       <= 2'd0;
        r_crmd_ie        <= 1'b0;
        r_era            <= io_bus.wb_pc;
        r_estat_ecode    <= io_bus.wb_ecode;
        r_estat_esubcode <= io_bus.wb_esubcode;
        if (io_bus.wb_ecode == ECODE_ADEF) begin
          r_badv <= io_bus.wb_pc;
        end else if (io_bus.wb_ecode == ECODE_ALE) begin
          r_badv <= io_bus.wb_vaddr;
        end
      end else if (io_bus.ertn_flush) begin
        r_crmd_plv <= r_prmd_pplv;
        r_crmd_ie  <= r_prmd_pie;
      end else if (w_wr_en) begin
        case (io_bus.csr_num)
          CSR_CRMD: begin
            r_crmd_plv <= w_wdata[1:0];
            r_crmd_ie  <= w_wdata[2];
            r_crmd_da  <= w_wdata[3];
            r_crmd_pg  <= w_wdata[4];
          end
          CSR_PRMD: begin
            r_prmd_pplv <= w_wdata[1:0];
            r_prmd_pie  <= w_wdata[2];
          end
          CSR_ECFG:   r_ecfg_lie <= {w_wdata[12:11], 1'b0, w_wdata[9:0]};
          CSR_ESTAT:  r_estat_is[1:0] <= w_wdata[1:0];
          CSR_ERA:    r_era <= w_wdata;
          CSR_BADV:   r_badv <= w_wdata;
          CSR_EENTRY: r_eentry_va <= w_wdata[31:6];
          CSR_SAVE0:  r_save[0] <= w_wdata;
          CSR_SAVE1:  r_save[1] <= w_wdata;
          CSR_SAVE2:  r_save[2] <= w_wdata;
          CSR_SAVE3:  r_save[3] <= w_wdata;
          CSR_TID:    r_tid <= w_wdata;
          CSR_TCFG: begin
            r_tcfg_en      <= w_wdata[0];
            r_tcfg_per     <= w_wdata[1];
            r_tcfg_initval <= w_wdata[31:2];
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.csr_rvalue = w_rvalue;
  assign io_bus.has_int    = (|(r_estat_is & r_ecfg_lie)) & r_crmd_ie;
  assign io_bus.ex_entry   = {r_eentry_va, 6'd0};
  assign io_bus.ertn_entry = r_era;

  // The read strobe is informational only.
  assign w_unused = io_bus.csr_re;

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Bench for csr_exc_ctrl: directed plan with literal expectations, then randomized
// traffic checked every cycle against a word-level model of the CSR file.
module tb_csr_exc_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  csr_exc_ctrl_if bus();
  csr_exc_ctrl dut (.clk(clk), .resetn(resetn), .io_bus(bus.slave));

  int errors = 0;
  int checks = 0;
  logic [7:0] hw_level = 8'd0;

  // Model: each CSR as a whole word plus a mask of software-writable bits.
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
    m_eentry = 0; m_tid = 0; m_tcfg = 0; m_tval = 0;
    for (int i = 0; i < 4; i++) m_save[i] = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [13:0] idx);
    case (idx)
      14'h00: return m_crmd;
      14'h01: return m_prmd;
      14'h04: return m_ecfg;
      14'h05: return m_estat;
      14'h06: return m_era;
      14'h07: return m_badv;
      14'h0c: return m_eentry;
      14'h30: return m_save[0];
      14'h31: return m_save[1];
      14'h32: return m_save[2];
      14'h33: return m_save[3];
      14'h40: return m_tid;
      14'h41: return m_tcfg;
      14'h42: return m_tval;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] sw_mask(input logic [13:0] idx);
    case (idx)
      14'h00: return 32'h0000_001f;
      14'h01: return 32'h0000_0007;
      14'h04: return 32'h0000_1bff;
      14'h05: return 32'h0000_0003;
      14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hffff_ffff;
      14'h0c: return 32'hffff_ffc0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_store(input logic [13:0] idx, input logic [31:0] v);
    case (idx)
      14'h00: m_crmd = v;
      14'h01: m_prmd = v;
      14'h04: m_ecfg = v;
      14'h05: m_estat = v;
      14'h06: m_era = v;
      14'h07: m_badv = v;
      14'h0c: m_eentry = v;
      14'h30: m_save[0] = v;
      14'h31: m_save[1] = v;
      14'h32: m_save[2] = v;
      14'h33: m_save[3] = v;
      14'h40: m_tid = v;
      14'h41: m_tcfg = v;
      default: ;
    endcase
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    logic [31:0] old_tval, old_tcfg, nv, wm, old;
    logic tcfg_wr, clr, fire;
    if (!resetn) begin
      m_reset();
      return;
    end
    old_tval = m_tval; old_tcfg = m_tcfg;
    tcfg_wr = 0; clr = 0; fire = 0;
    if (bus.wb_ex) begin
      m_prmd = m_crmd & 32'h7;
      m_crmd = m_crmd & ~32'h7;
      m_era = bus.wb_pc;
      m_estat = (m_estat & ~32'h7fff_0000) | (32'(bus.wb_ecode) << 16) | (32'(bus.wb_esubcode) << 22);
      if (bus.wb_ecode == 6'h08) m_badv = bus.wb_pc;
      else if (bus.wb_ecode == 6'h09) m_badv = bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      m_crmd = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
    end else if (bus.csr_we) begin
      old = m_read(bus.csr_num);
      wm = sw_mask(bus.csr_num);
      nv = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & old);
      m_store(bus.csr_num, (old & ~wm) | (nv & wm));
      tcfg_wr = (bus.csr_num == 14'h41);
      clr = (bus.csr_num == 14'h44) && nv[0];
    end
    if (tcfg_wr) m_tval = m_tcfg & ~32'h3;
    else if (old_tcfg[0]) begin
      if (old_tval != 0) begin
        m_tval = old_tval - 1;
        fire = (old_tval == 1);
      end else if (old_tcfg[1]) m_tval = old_tcfg & ~32'h3;
    end
    m_estat[9:2] = bus.hw_int_in;
    m_estat[12] = bus.ipi_int_in;
    if (fire) m_estat[11] = 1'b1;
    else if (clr) m_estat[11] = 1'b0;
  endtask

  task automatic compare_all();
    logic exp_int;
    exp_int = ((m_estat[12:0] & m_ecfg[12:0]) != 0) && m_crmd[2];
    chk("csr_rvalue", bus.csr_rvalue, m_read(bus.csr_num));
    chk("has_int", {31'd0, bus.has_int}, {31'd0, exp_int});
    chk("ex_entry", bus.ex_entry, m_eentry);
    chk("ertn_entry", bus.ertn_entry, m_era);
  endtask

  // Called just after a falling edge with inputs set; returns just after the next one.
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.csr_re = 0; bus.csr_num = 0; bus.csr_we = 0; bus.csr_wmask = 0; bus.csr_wvalue = 0;
    bus.wb_ex = 0; bus.wb_ecode = 0; bus.wb_esubcode = 0; bus.wb_pc = 0; bus.wb_vaddr = 0;
    bus.ertn_flush = 0; bus.hw_int_in = hw_level; bus.ipi_int_in = 0;
  endtask

  task automatic wr(input logic [13:0] idx, input logic [31:0] mask, input logic [31:0] val);
    idle_in();
    bus.csr_we = 1; bus.csr_num = idx; bus.csr_wmask = mask; bus.csr_wvalue = val;
    step();
    idle_in();
  endtask

  task automatic lit(input string name, input logic [13:0] idx, input logic [31:0] exp);
    bus.csr_num = idx;
    #1 chk(name, bus.csr_rvalue, exp);
  endtask

  int idx_tab [15] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0c, 'h30, 'h31, 'h32, 'h33,
                       'h40, 'h41, 'h42, 'h44};

  initial begin
    int k;
    idle_in();
    resetn = 0;
    repeat (2) @(posedge clk);
    m_reset();
    @(negedge clk);
    resetn = 1;

    // Reset state and basic readback.
    lit("crmd_reset", 14'h0, 32'h8);
    lit("unknown_reset", 14'h99, 32'h0);
    chk("has_int_reset", {31'd0, bus.has_int}, 32'd0);
    step();
    chk("ex_entry_reset", bus.ex_entry, 32'd0);
    wr(14'h0, 32'h7, 32'h7);
    lit("crmd_write", 14'h0, 32'hf);
    lit("unknown_read", 14'h99, 32'h0);
    step();

    // ALE exception followed by ertn.
    idle_in();
    bus.wb_ex = 1; bus.wb_ecode = 6'h09; bus.wb_pc = 32'h1c00_0100; bus.wb_vaddr = 32'h1234;
    step();
    idle_in();
    lit("prmd_after_ex", 14'h1, 32'h7);
    lit("crmd_after_ex", 14'h0, 32'h8);
    lit("era_after_ex", 14'h6, 32'h1c00_0100);
    step();
    lit("badv_after_ale", 14'h7, 32'h1234);
    lit("estat_after_ale", 14'h5, 32'h0009_0000);
    chk("ertn_entry_ale", bus.ertn_entry, 32'h1c00_0100);
    step();
    bus.ertn_flush = 1;
    step();
    idle_in();
    lit("crmd_after_ertn", 14'h0, 32'hf);
    step();

    // Software write to ERA loses to a simultaneous exception.
    bus.csr_we = 1; bus.csr_num = 14'h6; bus.csr_wmask = 32'hffff_ffff; bus.csr_wvalue = 32'hdead_beef;
    bus.wb_ex = 1; bus.wb_ecode = 6'h01; bus.wb_pc = 32'h1c00_0200;
    step();
    idle_in();
    lit("era_conflict", 14'h6, 32'h1c00_0200);
    step();

    // One-shot timer.
    wr(14'h0, 32'h7, 32'h4);
    wr(14'h4, 32'hffff_ffff, 32'h800);
    wr(14'h41, 32'hffff_ffff, 32'h9);
    lit("tval_load", 14'h42, 32'h8);
    for (int i = 7; i >= 0; i--) step();
    lit("tval_zero", 14'h42, 32'h0);
    lit("estat_timer", 14'h5, 32'h0001_0800);
    chk("has_int_timer", {31'd0, bus.has_int}, 32'd1);
    step();
    lit("tval_hold", 14'h42, 32'h0);
    wr(14'h44, 32'h1, 32'h1);
    lit("estat_ticlr", 14'h5, 32'h0001_0000);
    chk("has_int_ticlr", {31'd0, bus.has_int}, 32'd0);

    // Periodic timer.
    wr(14'h41, 32'hffff_ffff, 32'hb);
    for (int i = 0; i < 7; i++) step();
    lit("tval_per_one", 14'h42, 32'h1);
    step();
    lit("estat_per1", 14'h5, 32'h0001_0800);
    step();
    lit("tval_reload", 14'h42, 32'h8);
    wr(14'h44, 32'h1, 32'h1);
    for (int i = 0; i < 7; i++) step();
    lit("estat_per2", 14'h5, 32'h0001_0800);
    wr(14'h41, 32'hffff_ffff, 32'h0);
    wr(14'h44, 32'h1, 32'h1);

    // Hardware interrupt masking.
    wr(14'h4, 32'hffff_ffff, 32'h4);
    hw_level = 8'h01;
    idle_in();
    chk("has_int_hw_pre", {31'd0, bus.has_int}, 32'd0);
    step();
    chk("has_int_hw", {31'd0, bus.has_int}, 32'd1);
    wr(14'h0, 32'h4, 32'h0);
    chk("has_int_ie_off", {31'd0, bus.has_int}, 32'd0);
    hw_level = 8'h00;
    idle_in();
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      resetn = ($urandom_range(0, 299) != 0);
      bus.csr_re = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 15);
      bus.csr_num = (k == 15) ? 14'($urandom) : 14'(idx_tab[k]);
      bus.csr_we = ($urandom_range(0, 2) == 0);
      bus.csr_wmask = $urandom_range(0, 1) ? 32'hffff_ffff : 32'($urandom);
      bus.csr_wvalue = 32'($urandom);
      if (bus.csr_num == 14'h41 && $urandom_range(0, 3) != 0) bus.csr_wvalue = 32'($urandom_range(0, 31));
      bus.wb_ex = ($urandom_range(0, 15) == 0);
      bus.ertn_flush = ($urandom_range(0, 15) == 0);
      k = $urandom_range(0, 3);
      bus.wb_ecode = (k == 0) ? 6'h08 : (k == 1) ? 6'h09 : 6'($urandom);
      bus.wb_esubcode = 9'($urandom);
      bus.wb_pc = 32'($urandom);
      bus.wb_vaddr = 32'($urandom);
      if ($urandom_range(0, 7) == 0) bus.hw_int_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.ipi_int_in = 1'($urandom_range(0, 1));
      step();
    end
    resetn = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_exc_ctrl.md
# csr_exc_ctrl

Control-and-status register file and exception/interrupt sequencer for the single-issue LoongArch pipeline. It serves the write-back stage's CSR read/write port and commits exception and `ertn` state changes at the WB commit edge. It also runs the constant timer and produces the interrupt request sampled by decode, plus the redirect targets used for pipeline flush.

## Interface
- No parameters.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `csr_re` in 1: WB reads a CSR this cycle; informational only, `csr_rvalue` does not depend on it.
- `csr_num` in 14: CSR index for read and write.
- `csr_rvalue` out 32: combinational read of `csr_num`.
- `csr_we` in 1: masked write strobe.
- `csr_wmask` in 32: per-bit write enable.
- `csr_wvalue` in 32: write data.
- `wb_ex` in 1: exception commits this cycle.
- `wb_ecode` in 6: exception Ecode.
- `wb_esubcode` in 9: exception EsubCode.
- `wb_pc` in 32: PC of the committing instruction.
- `wb_vaddr` in 32: faulting data address, meaningful for ALE.
- `ertn_flush` in 1: `ertn` commits this cycle.
- `hw_int_in` in 8: level hardware interrupts.
- `ipi_int_in` in 1: level inter-processor interrupt.
- `has_int` out 1: enabled interrupt pending.
- `ex_entry` out 32: exception handler target, equal to EENTRY.
- `ertn_entry` out 32: return target, equal to ERA.

## Operation
- **Registers, indices and fields.** Unlisted bits read 0 and ignore writes.
  - CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[9:0], LIE[12:11].
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22].
  - ERA 0x6, BADV 0x7, SAVE0–3 0x30–0x33, TID 0x40: 32-bit fields.
  - EENTRY 0xc: VA[31:6].
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: CLR[0], write-1, always reads 0.
  - Unknown index: reads 0, writes dropped.
- **Masked write.** new = (wmask & wvalue) | (~wmask & old), applied only to software-writable bits.
- **ESTAT write rules.**
  - IS[1:0] is software-writable.
  - IS[9:2] is loaded from `hw_int_in` every cycle.
  - IS[12] is loaded from `ipi_int_in` every cycle.
  - IS[11] is the timer bit.
  - Ecode and EsubCode are written only by exceptions.
- **Exception commit (`wb_ex`=1).**
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0; CRMD.IE<=0.
  - ERA<=`wb_pc`; ESTAT.Ecode/EsubCode<=inputs.
  - BADV<=`wb_pc` if Ecode=0x08 (ADEF); BADV<=`wb_vaddr` if Ecode=0x09 (ALE); otherwise BADV is unchanged.
- **`ertn` commit.** CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
- **Priority.** `wb_ex` > `ertn_flush` > `csr_we`. A `csr_we` in the same cycle as `wb_ex` or `ertn_flush` is discarded entirely.
- **Timer.**
  - A TCFG write loads TVAL<={new InitVal,2'b00}.
  - If En=1 and TVAL≠0: TVAL decrements by 1 per cycle.
  - TVAL 1→0 sets IS[11] on the same edge.
  - If En=1, TVAL=0 and Periodic=1: reload {InitVal,2'b00}.
  - If Periodic=0: TVAL holds at 0.
  - If En=0: TVAL holds.
- **TICLR.** A write with effective CLR=1 clears IS[11]. If a timer set and a clear fall on the same edge, the set wins.
- **Interrupt request.** `has_int` = |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE, purely combinational.

## Timing
- All state updates on posedge `clk`.
- `csr_rvalue`, `has_int`, `ex_entry` and `ertn_entry` are combinational from current state. A read in the same cycle as a write returns the old value; the new value is visible the next cycle.
- Interrupt inputs reach `has_int` one cycle after they are asserted, via the IS sample.
- **Reset** (`resetn`=0 at an edge):
  - CRMD=0x0000_0008 (DA=1).
  - All other registers 0, TVAL included.
  - Outputs after reset: `has_int`=0, `ex_entry`=0, `ertn_entry`=0, and `csr_rvalue`=0 for every index except CRMD (0x8).
- Reset overrides every simultaneous event, including an in-flight timer countdown.
- At most one of `wb_ex` and `ertn_flush` is asserted per cycle. If both are asserted, `wb_ex` governs.

## Test plan
- **Reset and readback.** Reset, then read 0x0 → 0x00000008. Write CRMD mask 0x7, value 0x7, then read → 0x0000000F. Read 0x99 → 0.
- **ALE exception.** Set CRMD.PLV=3, IE=1. Pulse `wb_ex` with ecode 0x09, `wb_pc`=0x1c000100, `wb_vaddr`=0x1234. Next cycle: PRMD=0x7, CRMD[2:0]=0, ERA=0x1c000100, BADV=0x1234, ESTAT[21:16]=0x09. Then pulse `ertn` → CRMD[2:0]=0x7.
- **Same-cycle conflict.** `csr_we` to ERA together with `wb_ex` → ERA = `wb_pc`; the write is discarded.
- **One-shot timer.** TCFG=0x9 (InitVal 2, En, one-shot) → TVAL=8 next cycle, counting 8…1,0. IS[11]=1 on the edge reaching 0, and TVAL stays 0. With LIE[11]=1 and IE=1 → `has_int`=1. Write TICLR 1 → IS[11]=0, `has_int`=0.
- **Periodic timer.** TCFG=0xB → TVAL reloads to 8 one cycle after reaching 0, and IS[11] is set each period.
- **Hardware interrupt masking.** `hw_int_in`=0x01 with LIE[2]=1 and IE=1 → `has_int`=1 one cycle later. Clear IE via CSR write → `has_int`=0.
